keypad_key_queue: RTL and testbench
===================================

Name: keypad_key_queue

Overview:
- Sits directly downstream of the keypad driver. Consumes its 4-bit key code and its 3-cycle press interrupt, and queues key codes in a small FIFO.
- Presents the FIFO head to the MCU as an 8-bit input-port word and pops it on an MCU read strobe.
- Raises an interrupt pulse to the MCU for every key it accepts, so no key is lost when presses arrive faster than the ISR services them.

Parameters:
- DEPTH, 8, FIFO entries; power of two, 2..16.
- CAPTURE_DLY, 2, CLK cycles from the KEY_INT rising edge to sampling KEY_DATA; range 1..7.
- INT_CYCLES, 3, width of the INT_OUT pulse in CLK cycles; range 1..15.

Ports:
- CLK  in  1  system clock (MCU clock)
- RST_N  in  1  asynchronous active-low reset
- KEY_DATA  in  4  key code from the keypad driver; stable while KEY_INT is high
- KEY_INT  in  1  press interrupt from the keypad driver; multi-cycle high pulse
- RD_EN  in  1  MCU port-read strobe; one-cycle pop request
- CLR  in  1  synchronous flush; also clears OVF
- OUT_DATA  out  8  {VALID, OVF, 2'b00, CODE[3:0]} of the FIFO head
- COUNT  out  $clog2(DEPTH+1)  current occupancy
- INT_OUT  out  1  interrupt pulse to the MCU

Behaviour:
- Reset (RST_N low, asynchronous):
  - FIFO empty, pointers 0, COUNT=0, OVF=0.
  - Capture FSM in IDLE, INT_OUT=0.
  - OUT_DATA=8'h00.
- Edge detect: KEY_INT is registered once. A rising edge is prev=0 and cur=1. Only rising edges matter; pulse length is irrelevant.
- Capture FSM states:
  - IDLE: on a rising edge, load the delay counter with CAPTURE_DLY and go to WAIT.
  - WAIT: decrement the counter each cycle. When it reaches 1, sample KEY_DATA, issue a push that same cycle, and return to IDLE.
  - Rising edges seen while in WAIT are ignored.
  - Push latency from the KEY_INT rising edge = CAPTURE_DLY+1 cycles.
- Push:
  - If not full, or full with a simultaneous pop: write the code, advance the write pointer, COUNT+1 (unchanged if a pop happens in the same cycle).
  - If full without a pop: drop the code and set OVF. OVF is sticky until CLR or reset.
- Pop (RD_EN=1):
  - If not empty: advance the read pointer on the next edge, COUNT-1.
  - If empty: no effect, no error.
- Simultaneous push and pop:
  - Both take effect.
  - If the FIFO was empty, the pop is ignored and the push lands.
- Pointers are DEPTH-modulo and wrap naturally. COUNT never exceeds DEPTH and never underflows.
- OUT_DATA is combinational from the head entry:
  - VALID = (COUNT!=0).
  - CODE = head entry when VALID, else 4'h0.
  - OVF reflects the sticky flag regardless of VALID.
  - The MCU reads OUT_DATA in the same cycle it asserts RD_EN. The next entry appears in the following cycle.
- INT_OUT:
  - Each accepted push loads the pulse counter with INT_CYCLES, and INT_OUT = (counter!=0).
  - A push during an active pulse reloads the counter, extending the pulse.
  - Dropped pushes do not pulse.
- CLR (synchronous, highest priority over push and pop in the same cycle):
  - Empties the FIFO and clears OVF, COUNT and the pulse counter.
  - Sends the capture FSM to IDLE.
- RST_N deasserted mid-capture or mid-pulse: everything returns to its reset value immediately. No pending push survives.

Decomposition:
- Package keypad_pkg holds:
  - Key code constants: KEY_0..KEY_9 = 0..9, KEY_STAR = 10, KEY_HASH = 11.
  - OUT_DATA bit positions: VALID_BIT = 7, OVF_BIT = 6, CODE_LSB = 0.
  - The shared port ID for OUT_DATA.
- One sub-module, key_fifo: a generic synchronous FIFO (WIDTH, DEPTH; push, pop, clr, full, empty, count, head).
- The capture FSM, overflow flag and interrupt counter live in keypad_key_queue.

Test Plan:
- Single press: KEY_DATA=4'h5, KEY_INT high 3 cycles -> push at cycle 3 after the edge. OUT_DATA=8'h85, COUNT=1, INT_OUT high exactly 3 cycles. Then RD_EN 1 cycle -> OUT_DATA=8'h00 next cycle.
- Order and wrap: 12 presses with codes 0..11, popping after every 3rd push so occupancy stays ≤8 -> codes read back in exact order 0..11 across pointer wrap, no OVF.
- Overflow: 9 presses with no reads -> COUNT=8, ninth code dropped, OUT_DATA[6]=1, no INT_OUT for the ninth. CLR -> COUNT=0, OUT_DATA=8'h00.
- Full plus simultaneous pop and push: FIFO full, RD_EN coincides with the push cycle -> push accepted, COUNT stays 8, OVF stays 0.
- Empty read and retrigger: RD_EN on empty -> COUNT stays 0. Second KEY_INT edge 1 cycle into WAIT -> ignored, only one entry queued.
- Async reset: assert RST_N low during WAIT with INT_OUT high -> immediately INT_OUT=0, COUNT=0, OUT_DATA=8'h00. After release, no push occurs.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad key queue: key codes, port-word layout,
// capture FSM encoding and the helper that builds the MCU input-port word.
package keypad_pkg;

    localparam logic [3:0] KEY_0    = 4'd0;
    localparam logic [3:0] KEY_1    = 4'd1;
    localparam logic [3:0] KEY_2    = 4'd2;
    localparam logic [3:0] KEY_3    = 4'd3;
    localparam logic [3:0] KEY_4    = 4'd4;
    localparam logic [3:0] KEY_5    = 4'd5;
    localparam logic [3:0] KEY_6    = 4'd6;
    localparam logic [3:0] KEY_7    = 4'd7;
    localparam logic [3:0] KEY_8    = 4'd8;
    localparam logic [3:0] KEY_9    = 4'd9;
    localparam logic [3:0] KEY_STAR = 4'd10;
    localparam logic [3:0] KEY_HASH = 4'd11;

    localparam int VALID_BIT = 7;
    localparam int OVF_BIT   = 6;
    localparam int CODE_LSB  = 0;

    // MCU input-port address at which OUT_DATA is decoded
    localparam logic [7:0] KEYPAD_PORT_ID = 8'h21;

    localparam int DLY_W   = 3;
    localparam int PULSE_W = 4;

    typedef enum logic {
        CAP_IDLE = 1'b0,
        CAP_WAIT = 1'b1
    } cap_state_t;

    function automatic logic [7:0] pack_out_word(input logic valid, input logic ovf,
                                                 input logic [3:0] code);
        logic [7:0] word;
        word                  = 8'h00;
        word[VALID_BIT]       = valid;
        word[OVF_BIT]         = ovf;
        word[CODE_LSB +: 4]   = valid ? code : 4'h0;
        return word;
    endfunction

endpackage

// File: rtl/key_fifo.sv
// Generic synchronous FIFO with occupancy count; flush has priority over push/pop,
// and a pop on a full FIFO frees the slot for a same-cycle push.
module key_fifo #(
    parameter  int WIDTH = 4,
    parameter  int DEPTH = 8,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             clr,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_pop  = pop & ~clr & ~empty;
    assign do_push = push & ~clr & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by plain overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/keypad_key_queue.sv
// Queues keypad driver presses for the MCU: delayed KEY_DATA capture after each
// KEY_INT rising edge, FIFO head as an input-port word, interrupt per accepted key.
//
// state    | meaning
// CAP_IDLE | waiting for a KEY_INT rising edge
// CAP_WAIT | counting down to the KEY_DATA sample point; further edges ignored
module keypad_key_queue
    import keypad_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int CAPTURE_DLY = 2,
    parameter int INT_CYCLES  = 3
) (
    input  logic                         CLK,
    input  logic                         RST_N,
    input  logic [3:0]                   KEY_DATA,
    input  logic                         KEY_INT,
    input  logic                         RD_EN,
    input  logic                         CLR,
    output logic [7:0]                   OUT_DATA,
    output logic [$clog2(DEPTH+1)-1:0]   COUNT,
    output logic                         INT_OUT
);

    logic               key_int_cur;
    logic               key_int_prev;
    logic               key_rise;
    cap_state_t         state;
    cap_state_t         state_nxt;
    logic [DLY_W-1:0]   dly_cnt;
    logic [DLY_W-1:0]   dly_nxt;
    logic               push_req;
    logic               push_ok;
    logic               full;
    logic               empty;
    logic               ovf;
    logic [PULSE_W-1:0] pulse_cnt;
    logic [3:0]         head;

    // The driver is on another clock domain, so its interrupt is sampled before edge detection
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            key_int_cur  <= 1'b0;
            key_int_prev <= 1'b0;
        end else begin
            key_int_cur  <= KEY_INT;
            key_int_prev <= key_int_cur;
        end
    end

    assign key_rise = key_int_cur & ~key_int_prev;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= CAP_IDLE;
            dly_cnt <= '0;
        end else begin
            state   <= state_nxt;
            dly_cnt <= dly_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        dly_nxt   = dly_cnt;
        if (CLR) begin
            state_nxt = CAP_IDLE;
            dly_nxt   = '0;
        end else begin
            case (state)
                CAP_IDLE: begin
                    if (key_rise) begin
                        state_nxt = CAP_WAIT;
                        dly_nxt   = DLY_W'(CAPTURE_DLY);
                    end
                end
                CAP_WAIT: begin
                    if (dly_cnt <= DLY_W'(1)) begin
                        state_nxt = CAP_IDLE;
                        dly_nxt   = '0;
                    end else begin
                        dly_nxt = dly_cnt - DLY_W'(1);
                    end
                end
                default: begin
                    state_nxt = CAP_IDLE;
                    dly_nxt   = '0;
                end
            endcase
        end
    end

    always_comb begin
        push_req = 1'b0;
        if (state == CAP_WAIT && dly_cnt == DLY_W'(1)) begin
            push_req = 1'b1;
        end
    end

    // A full FIFO still accepts the key when the MCU pops the head in the same cycle
    assign push_ok = push_req & ~CLR & (~full | RD_EN);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ovf       <= 1'b0;
            pulse_cnt <= '0;
        end else if (CLR) begin
            ovf       <= 1'b0;
            pulse_cnt <= '0;
        end else begin
            if (push_req && full && !RD_EN) begin
                ovf <= 1'b1;
            end
            if (push_ok) begin
                pulse_cnt <= PULSE_W'(INT_CYCLES);
            end else if (pulse_cnt != '0) begin
                pulse_cnt <= pulse_cnt - PULSE_W'(1);
            end
        end
    end

    key_fifo #(
        .WIDTH (4),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst_n (RST_N),
        .push  (push_req),
        .pop   (RD_EN),
        .clr   (CLR),
        .din   (KEY_DATA),
        .full  (full),
        .empty (empty),
        .count (COUNT),
        .head  (head)
    );

    assign INT_OUT  = (pulse_cnt != '0);
    assign OUT_DATA = pack_out_word(~empty, ovf, head);

endmodule

// File: tb/tb_keypad_key_queue.sv
// Bench for keypad_key_queue: directed scenarios plus random presses/reads/flushes,
// all checked against a queue-based reference model of the key queue.
module tb_keypad_key_queue;
    import keypad_pkg::*;

    localparam int DEPTH       = 8;
    localparam int CAPTURE_DLY = 2;
    localparam int INT_CYCLES  = 3;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic [3:0] key_data = 4'h0;
    logic       key_int  = 1'b0;
    logic       rd_en    = 1'b0;
    logic       clr      = 1'b0;
    logic [7:0] out_data;
    logic [3:0] count;
    logic       int_out;

    int n_checks = 0;
    int n_errors = 0;
    bit mon_en   = 1'b0;

    // reference model: queue of accepted codes, sticky overflow, pulse time left,
    // and the edge at which a pending capture lands in the queue
    logic [3:0] mq [$];
    bit         m_ovf   = 1'b0;
    int         m_pulse = 0;
    bit         m_pend  = 1'b0;
    int         m_due   = 0;
    int         m_edge  = 0;
    bit         m_in1   = 1'b0;
    bit         m_in2   = 1'b0;

    logic [3:0] keys [12];

    keypad_key_queue #(
        .DEPTH       (DEPTH),
        .CAPTURE_DLY (CAPTURE_DLY),
        .INT_CYCLES  (INT_CYCLES)
    ) dut (
        .CLK      (clk),
        .RST_N    (rst_n),
        .KEY_DATA (key_data),
        .KEY_INT  (key_int),
        .RD_EN    (rd_en),
        .CLR      (clr),
        .OUT_DATA (out_data),
        .COUNT    (count),
        .INT_OUT  (int_out)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        bit rise;
        bit idle;
        bit acc;
        int sz;
        if (!rst_n) begin
            mq.delete();
            m_ovf   = 1'b0;
            m_pulse = 0;
            m_pend  = 1'b0;
            m_in1   = 1'b0;
            m_in2   = 1'b0;
        end else begin
            // a rise sampled at edge e-1 starts a capture at edge e and lands at e+CAPTURE_DLY
            rise = m_in1 && !m_in2;
            idle = !m_pend;
            acc  = 1'b0;
            if (clr) begin
                mq.delete();
                m_ovf   = 1'b0;
                m_pulse = 0;
                m_pend  = 1'b0;
            end else begin
                sz = mq.size();
                if (rd_en && sz > 0) void'(mq.pop_front());
                if (m_pend && m_edge == m_due) begin
                    m_pend = 1'b0;
                    if (sz < DEPTH || rd_en) begin
                        mq.push_back(key_data);
                        acc = 1'b1;
                    end else begin
                        m_ovf = 1'b1;
                    end
                end
                if (acc) m_pulse = INT_CYCLES;
                else if (m_pulse > 0) m_pulse--;
                if (idle && rise) begin
                    m_pend = 1'b1;
                    m_due  = m_edge + CAPTURE_DLY;
                end
            end
            m_in2 = m_in1;
            m_in1 = key_int;
            m_edge++;
        end
    end

    always @(negedge clk) begin
        logic [7:0] e;
        if (mon_en && rst_n) begin
            e    = 8'h00;
            e[6] = m_ovf;
            if (mq.size() != 0) begin
                e[7]   = 1'b1;
                e[3:0] = mq[0];
            end
            check_val("mon_out_data", out_data, e);
            check_val("mon_count", count, mq.size());
            check_val("mon_int_out", int_out, m_pulse != 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] code, input bit rd_at_push);
        key_data = code;
        key_int  = 1'b1;
        repeat (3) tick();
        key_int = 1'b0;
        rd_en   = rd_at_push;
        tick();
        rd_en = 1'b0;
        tick();
    endtask

    task automatic pop_expect(input logic [3:0] code);
        check_val("pop_head", out_data, {4'h8, code});
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic flush();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nxt;
        keys = '{KEY_0, KEY_1, KEY_2, KEY_3, KEY_4, KEY_5,
                 KEY_6, KEY_7, KEY_8, KEY_9, KEY_STAR, KEY_HASH};
        $display("keypad key queue bench, port id 0x%0h", KEYPAD_PORT_ID);

        repeat (3) @(posedge clk);
        #1;
        check_val("rst_out_data", out_data, 8'h00);
        check_val("rst_count", count, 0);
        check_val("rst_int_out", int_out, 0);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        tick();

        // single press: push lands on the third edge after the first KEY_INT sample
        key_data = KEY_5;
        key_int  = 1'b1;
        repeat (3) tick();
        key_int = 1'b0;
        check_val("single_pre_count", count, 0);
        tick();
        check_val("single_out", out_data, 8'h85);
        check_val("single_count", count, 1);
        check_val("single_int1", int_out, 1);
        tick();
        check_val("single_int2", int_out, 1);
        tick();
        check_val("single_int3", int_out, 1);
        tick();
        check_val("single_int_end", int_out, 0);
        rd_en = 1'b1;
        #1;
        check_val("single_read_same", out_data, 8'h85);
        tick();
        rd_en = 1'b0;
        check_val("single_after_read", out_data, 8'h00);
        check_val("single_after_count", count, 0);

        // ordering across pointer wrap
        nxt = 0;
        for (int i = 0; i < 12; i++) begin
            press(keys[i], 1'b0);
            if (i % 3 == 2) begin
                pop_expect(4'(nxt)); nxt++;
                pop_expect(4'(nxt)); nxt++;
            end
        end
        check_val("wrap_count", count, 4);
        while (nxt < 12) begin
            pop_expect(4'(nxt));
            nxt++;
        end
        check_val("wrap_empty", out_data, 8'h00);

        // overflow
        for (int i = 0; i < 8; i++) press(keys[i], 1'b0);
        check_val("ovf_count_full", count, 8);
        check_val("ovf_not_yet", out_data, 8'h80);
        press(KEY_8, 1'b0);
        check_val("ovf_count", count, 8);
        check_val("ovf_out", out_data, 8'hC0);
        check_val("ovf_no_int", int_out, 0);
        flush();
        check_val("clr_out", out_data, 8'h00);
        check_val("clr_count", count, 0);

        // full FIFO, pop coincides with push
        for (int i = 0; i < 8; i++) press(keys[11-i], 1'b0);
        press(KEY_0, 1'b1);
        check_val("fullpp_count", count, 8);
        check_val("fullpp_out", out_data, 8'h8A);
        check_val("fullpp_int", int_out, 1);
        flush();

        // empty read, then a second edge during WAIT
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check_val("empty_read_count", count, 0);
        check_val("empty_read_out", out_data, 8'h00);
        key_data = KEY_7;
        key_int  = 1'b1;
        tick();
        key_int = 1'b0;
        tick();
        key_int = 1'b1;
        tick();
        tick();
        key_int = 1'b0;
        repeat (4) tick();
        check_val("retrig_count", count, 1);
        check_val("retrig_out", out_data, 8'h87);
        pop_expect(KEY_7);

        // random presses, reads and flushes
        for (int c = 0; c < 600; c++) begin
            int rd_pct;
            rd_pct = (c < 300) ? 6 : 40;
            if ($urandom_range(0, 3) == 0) begin
                if (!key_int) key_data = 4'($urandom_range(0, 15));
                key_int = ~key_int;
            end
            rd_en = ($urandom_range(0, 99) < rd_pct);
            clr   = ($urandom_range(0, 99) < 2);
            tick();
        end
        key_int = 1'b0;
        rd_en   = 1'b0;
        clr     = 1'b0;
        repeat (2) tick();
        flush();

        // async reset in WAIT with the interrupt pulse active
        key_data = KEY_1;
        key_int  = 1'b1;
        repeat (3) tick();
        key_int = 1'b0;
        tick();
        key_data = KEY_2;
        key_int  = 1'b1;
        tick();
        key_int = 1'b0;
        tick();
        check_val("arst_pre_int", int_out, 1);
        check_val("arst_pre_count", count, 1);
        rst_n = 1'b0;
        #1;
        check_val("arst_int", int_out, 0);
        check_val("arst_count", count, 0);
        check_val("arst_out", out_data, 8'h00);
        #1;
        rst_n = 1'b1;
        repeat (6) tick();
        check_val("arst_no_push_count", count, 0);
        check_val("arst_no_push_out", out_data, 8'h00);
        check_val("arst_no_push_int", int_out, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
